// File: rtl/vme_msfsm_arb_ctrl.sv
// Round-robin arbiter of NCH VME-style requesters onto one lds/ldtack device handshake, split into channel and device FSMs.
// Optional ldtack timeout (sticky per-channel err) is built when MSFSM_LDTACK_TIMEOUT_EN is defined.
module vme_msfsm_arb_ctrl #(
  parameter int NCH  = 2,
  parameter int DW   = 8,
  parameter int TO_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    dsr,
  input  logic [NCH-1:0]    dsw,
  input  logic [NCH*DW-1:0] wdata,
  output logic [NCH-1:0]    dtack,
  output logic [NCH-1:0]    grant,
  output logic [DW-1:0]     rdata,
  output logic [NCH-1:0]    err,
  output logic              lds,
  input  logic              ldtack,
  output logic              d,
  output logic              dev_we,
  output logic [DW-1:0]     dev_wdata,
  input  logic [DW-1:0]     dev_rdata
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  if (NCH < 2 || NCH > 8 || DW < 1 || TO_W < 1) begin : g_bad_cfg
    $error("vme_msfsm_arb_ctrl: unsupported parameter set");
  end

  typedef enum logic [2:0] {C_IDLE, C_GRANT, C_WAIT, C_ACK, C_REL} cst_e;
  typedef enum logic [1:0] {D_IDLE, D_UP, D_DN} dst_e;

  cst_e cst_q, cst_d;
  dst_e dst_q, dst_d;

  logic [NCH-1:0] req, grant_q, grant_d;
  logic [IW-1:0]  sel, owner_q, owner_d, last_q, last_d;
  logic [DW-1:0]  wsel, wdat_q, wdat_d, rdata_q, rdata_d;
  logic           we_q, we_d, d_q, d_d, dten_q, dten_d;
  logic           req_own, tmo, to_hold;

  // First requester strictly after 'last'; scanning farthest-first lets the nearest overwrite.
  function automatic logic [IW-1:0] rr_pick(input logic [NCH-1:0] r, input logic [IW-1:0] last);
    logic [IW-1:0] p;
    p = last;
    for (int k = NCH; k >= 1; k--) begin
      int c;
      c = (int'(last) + k) % NCH;
      if (r[c[IW-1:0]]) p = c[IW-1:0];
    end
    return p;
  endfunction

  assign req     = dsr | dsw;
  assign sel     = rr_pick(req, last_q);
  assign req_own = req[owner_q];

  always_comb begin
    wsel = '0;
    for (int i = 0; i < NCH; i++)
      if (sel == IW'(i)) wsel = wdata[i*DW +: DW];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cst_q <= C_IDLE;
      dst_q <= D_IDLE;
    end else begin
      cst_q <= cst_d;
      dst_q <= dst_d;
    end
  end

  always_comb begin
    cst_d = cst_q;
    unique case (cst_q)
      C_IDLE:  if (|req) cst_d = C_GRANT;
      C_GRANT: cst_d = C_WAIT;
      C_WAIT: begin
        if (ldtack)   cst_d = req_own ? C_ACK : C_REL;
        else if (tmo) cst_d = C_ACK;
      end
      C_ACK:   if (!req_own) cst_d = C_REL;
      C_REL:   if (!ldtack) cst_d = C_IDLE;
      default: cst_d = C_IDLE;
    endcase
  end

  // Device side follows the channel FSM: strobe up after the grant, down once the channel releases.
  always_comb begin
    dst_d = dst_q;
    unique case (dst_q)
      D_IDLE:  if (cst_q == C_GRANT) dst_d = D_UP;
      D_UP:    if (cst_d == C_REL) dst_d = D_DN;
      D_DN:    if (cst_q == C_REL && !ldtack) dst_d = D_IDLE;
      default: dst_d = D_IDLE;
    endcase
  end

  always_comb begin
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    we_d    = we_q;
    wdat_d  = wdat_q;
    rdata_d = rdata_q;
    if (cst_q == C_IDLE && |req) begin
      owner_d = sel;
      grant_d = {{(NCH-1){1'b0}}, 1'b1} << sel;
      we_d    = dsw[sel];
      wdat_d  = wsel;
    end
    if (cst_q == C_WAIT && ldtack && !we_q) rdata_d = dev_rdata;
    if (cst_q == C_REL && !ldtack) begin
      last_d  = owner_q;
      grant_d = '0;
    end
    // d only on a real ldtack; a timeout enters ACK with d low. dtack lags ACK entry by one edge.
    d_d    = (cst_d == C_ACK) && ((cst_q == C_ACK) ? d_q : ldtack);
    dten_d = (cst_q == C_ACK) && (cst_d == C_ACK);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_q <= '0;
      owner_q <= IW'(NCH - 1);
      last_q  <= IW'(NCH - 1);
      we_q    <= 1'b0;
      wdat_q  <= '0;
      rdata_q <= '0;
      d_q     <= 1'b0;
      dten_q  <= 1'b0;
    end else begin
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      wdat_q  <= wdat_d;
      rdata_q <= rdata_d;
      d_q     <= d_d;
      dten_q  <= dten_d;
    end
  end

`ifdef MSFSM_LDTACK_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_MAX  = '1;
  localparam logic [TO_W-1:0] TO_TRIG = TO_W'((1 << TO_W) - 2);

  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]  err_q, err_d;
  logic            to_q, to_d;

  // Fires on the WAIT edge at which the counter would reach its ceiling.
  assign tmo = (cst_q == C_WAIT) && !ldtack && (cnt_q == TO_TRIG);

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    to_d  = to_q;
    if (cst_q == C_IDLE && |req) begin
      err_d[sel] = 1'b0;
      to_d       = 1'b0;
    end
    if (cst_q == C_GRANT) cnt_d = '0;
    else if (cst_q == C_WAIT && !ldtack && cnt_q != TO_MAX) cnt_d = cnt_q + 1'b1;
    if (tmo) begin
      err_d[owner_q] = 1'b1;
      to_d           = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
      to_q  <= to_d;
    end
  end

  assign err     = err_q;
  assign to_hold = to_q;
`else
  assign tmo     = 1'b0;
  assign err     = '0;
  assign to_hold = 1'b0;
`endif

  assign lds       = ((cst_q == C_WAIT) || (cst_q == C_ACK && !to_hold)) && (dst_q == D_UP);
  assign dtack     = grant_q & {NCH{dten_q}};
  assign grant     = grant_q;
  assign rdata     = rdata_q;
  assign d         = d_q;
  assign dev_we    = we_q;
  assign dev_wdata = wdat_q;

endmodule
